// File: rtl/serial_subtractor_8bits_pkg.sv
// Shared constants and FSM state type for the bit-serial subtractor.
package serial_subtractor_8bits_pkg;

    // Default operand width in bits
    localparam int DEF_WIDTH = 8;

    // Width of the bit counter that walks through the operand bits
    localparam int CNT_W = 3;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_subtractor_8bits_if.sv
// Request/result bundle between a requester (master) and the serial subtractor (slave).
interface serial_subtractor_8bits_if
    import serial_subtractor_8bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             Start;
    logic [WIDTH-1:0] InA;
    logic [WIDTH-1:0] InB;
    logic             Busy;
    logic             Done;
    logic [WIDTH:0]   R;

    modport master (
        output Start,
        output InA,
        output InB,
        input  Busy,
        input  Done,
        input  R
    );

    modport slave (
        input  Start,
        input  InA,
        input  InB,
        output Busy,
        output Done,
        output R
    );
endinterface

// File: rtl/serial_subtractor_8bits_fullsub.sv
// One-bit full subtractor: difference and borrow-out of a - b - bin.
module FullSubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_8bits.sv
// Bit-serial subtractor: computes InA - InB LSB first, one bit per clock,
// and presents {borrow, difference} on R with a one-cycle Done pulse.
module serial_subtractor_8bits
    import serial_subtractor_8bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      Clk,
    input  logic                      Rst,
    serial_subtractor_8bits_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             nextState_s;
    logic [WIDTH-1:0]   opA_r;
    logic [WIDTH-1:0]   opB_r;
    logic [WIDTH-1:0]   result_r;
    logic               borrow_r;
    logic [CNT_W-1:0]   bitCnt_r;
    logic [WIDTH:0]     rOut_r;
    logic               busy_r;
    logic               done_r;
    logic               diffBit_s;
    logic               borrowNext_s;

    // Per-bit arithmetic on the current LSBs and the running borrow
    FullSubtractor uFullSub (
        .a    (opA_r[0]),
        .b    (opB_r[0]),
        .bin  (borrow_r),
        .d    (diffBit_s),
        .bout (borrowNext_s)
    );

    // Next-state decode for the IDLE/SHIFT/DONE controller
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.Start) begin
                    nextState_s = SHIFT;
                end else begin
                    nextState_s = IDLE;
                end
            end
            SHIFT: begin
                if (bitCnt_r == LAST_BIT) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = SHIFT;
                end
            end
            DONE: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register plus datapath: capture, shift, and result load
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r  <= IDLE;
            opA_r    <= '0;
            opB_r    <= '0;
            result_r <= '0;
            borrow_r <= 1'b0;
            bitCnt_r <= '0;
            rOut_r   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= nextState_s;
            // Flags follow the state being entered so they line up with it
            busy_r  <= (nextState_s == SHIFT);
            done_r  <= (nextState_s == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.Start) begin
                        opA_r    <= bus.InA;
                        opB_r    <= bus.InB;
                        result_r <= '0;
                        borrow_r <= 1'b0;
                        bitCnt_r <= '0;
                    end
                end
                SHIFT: begin
                    opA_r    <= opA_r >> 1;
                    opB_r    <= opB_r >> 1;
                    result_r <= {diffBit_s, result_r[WIDTH-1:1]};
                    borrow_r <= borrowNext_s;
                    bitCnt_r <= bitCnt_r + 1'b1;
                    // Last bit: publish the finished result as DONE is entered
                    if (bitCnt_r == LAST_BIT) begin
                        rOut_r <= {borrowNext_s, diffBit_s, result_r[WIDTH-1:1]};
                    end
                end
                default: begin
                    // DONE and unused codes: datapath holds
                end
            endcase
        end
    end

    assign bus.Busy = busy_r;
    assign bus.Done = done_r;
    assign bus.R    = rOut_r;

endmodule

// File: tb/tb_serial_subtractor_8bits.sv
// Directed and random self-checking bench for serial_subtractor_8bits.
module tb_serial_subtractor_8bits;

    logic Clk;
    logic Rst;
    int   total;
    int   bad;

    serial_subtractor_8bits_if #(.WIDTH(8)) bus ();

    serial_subtractor_8bits #(.WIDTH(8)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One operation from IDLE; cycle k = k-th cycle after the accepting edge.
    // Busy in cycles 1..8, Done in cycle 9, back to IDLE in cycle 10.
    task automatic doOp(input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] expR, input string tag, input bit full);
        bus.Start = 1'b1;
        bus.InA   = a;
        bus.InB   = b;
        step();
        bus.Start = 1'b0;
        bus.InA   = ~a;
        bus.InB   = a;
        for (int i = 1; i <= 8; i++) begin
            if (full) begin
                chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
                chk({tag, "_nodone"}, 32'(bus.Done), 32'd0);
            end
            step();
        end
        chk({tag, "_done"}, 32'(bus.Done), 32'd1);
        chk({tag, "_r"}, 32'(bus.R), 32'(expR));
        if (full) begin
            chk({tag, "_busylow"}, 32'(bus.Busy), 32'd0);
        end
        step();
        chk({tag, "_donepulse"}, 32'(bus.Done), 32'd0);
        if (full) begin
            chk({tag, "_rhold"}, 32'(bus.R), 32'(expR));
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] re;
        logic       expDone;
        logic       expBusy;

        total     = 0;
        bad       = 0;
        Rst       = 1'b1;
        bus.Start = 1'b0;
        bus.InA   = 8'h00;
        bus.InB   = 8'h00;
        step();
        step();
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_r", 32'(bus.R), 32'd0);
        Rst = 1'b0;
        step();
        chk("idle_busy", 32'(bus.Busy), 32'd0);

        // Directed vectors with hand-computed results
        doOp(8'h05, 8'h03, 9'h002, "d05_03", 1'b1);
        doOp(8'h03, 8'h05, 9'h1FE, "d03_05", 1'b1);
        doOp(8'h00, 8'hFF, 9'h101, "d00_FF", 1'b1);
        doOp(8'hFF, 8'h00, 9'h0FF, "dFF_00", 1'b1);
        doOp(8'h00, 8'h00, 9'h000, "d00_00", 1'b1);
        doOp(8'hA5, 8'h5A, 9'h04B, "dA5_5A", 1'b1);

        // Idle with Start low: nothing happens, R holds
        step();
        step();
        chk("idle_hold_busy", 32'(bus.Busy), 32'd0);
        chk("idle_hold_r", 32'(bus.R), 32'h04B);

        // Start held high; operands change mid-SHIFT. Ops accepted at edges 0 and 10.
        bus.Start = 1'b1;
        bus.InA   = 8'h10;
        bus.InB   = 8'h01;
        step();
        for (int cyc = 1; cyc <= 19; cyc++) begin
            if (cyc == 3) begin
                bus.InA = 8'hAA;
                bus.InB = 8'h55;
            end
            expDone = (cyc == 9) || (cyc == 19);
            expBusy = ((cyc >= 1) && (cyc <= 8)) || ((cyc >= 11) && (cyc <= 18));
            chk($sformatf("held_done_c%0d", cyc), 32'(bus.Done), 32'(expDone));
            chk($sformatf("held_busy_c%0d", cyc), 32'(bus.Busy), 32'(expBusy));
            if (cyc == 9) begin
                chk("held_r1", 32'(bus.R), 32'h00F);
            end
            if (cyc == 15) begin
                chk("held_r1_hold", 32'(bus.R), 32'h00F);
            end
            if (cyc == 19) begin
                chk("held_r2", 32'(bus.R), 32'h055);
                bus.Start = 1'b0;
            end
            step();
        end
        chk("held_end_done", 32'(bus.Done), 32'd0);
        step();
        chk("held_end_busy", 32'(bus.Busy), 32'd0);

        // Reset during SHIFT cycle 4 aborts the operation and clears R
        bus.Start = 1'b1;
        bus.InA   = 8'h77;
        bus.InB   = 8'h11;
        step();
        bus.Start = 1'b0;
        step();
        step();
        step();
        chk("abort_busy_pre", 32'(bus.Busy), 32'd1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_done", 32'(bus.Done), 32'd0);
        chk("abort_r", 32'(bus.R), 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("abort_nodone", 32'(bus.Done), 32'd0);
            step();
        end
        chk("abort_r_after", 32'(bus.R), 32'd0);

        // Random regression
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            re = {1'b0, ra} - {1'b0, rb};
            doOp(ra, rb, re, "rand", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
